// File: rtl/countdown_timer.sv
// countdown_timer
//   Preset hh:mm:ss countdown timer for the clock's timekeeping path. A BCD
//   preset is validated and converted to seconds, then counted down once per
//   clk_out rising edge (1 Hz). Remaining time is offered both as a seconds
//   count and as registered BCD digits for the display mux; expiry is flagged
//   as a held level (expired) and a one-edge pulse (done_p).
//
//   Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for a periodic timer.
//   On expiry the count reloads from the preset and the timer keeps running.
//
// Ports
//   clk_out            in   1 Hz timebase, rising edge
//   swrst              in   async reset, active high
//   cd                 in   mode enable; 0 freezes everything except swrst
//   ld / start / pause in   commands, priority ld > start > pause
//   ph1..ps2           in   preset BCD digits (hh tens/units, mm, ss)
//   REM_CNT            out  remaining seconds (17 bits)
//   ch1..cs2           out  remaining time as BCD digits, one edge behind REM_CNT
//   running            out  high while counting
//   expired            out  level, set at expiry until valid ld / accepted start
//   done_p             out  one-edge pulse at expiry
//   ld_err             out  one-edge pulse on a rejected load
module countdown_timer #(
  parameter int unsigned MAX_SEC = 86399
) (
  input  logic        clk_out,
  input  logic        swrst,
  input  logic        cd,
  input  logic        ld,
  input  logic        start,
  input  logic        pause,
  input  logic [3:0]  ph1,
  input  logic [3:0]  ph2,
  input  logic [3:0]  pm1,
  input  logic [3:0]  pm2,
  input  logic [3:0]  ps1,
  input  logic [3:0]  ps2,
  output logic [16:0] REM_CNT,
  output logic [3:0]  ch1,
  output logic [3:0]  ch2,
  output logic [3:0]  cm1,
  output logic [3:0]  cm2,
  output logic [3:0]  cs1,
  output logic [3:0]  cs2,
  output logic        running,
  output logic        expired,
  output logic        done_p,
  output logic        ld_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state_q, state_d;
  logic [16:0] preset_q, preset_d;
  logic [16:0] rem_q, rem_d;
  logic        expired_q, expired_d;
  logic        done_p_q, done_p_d;
  logic        ld_err_q, ld_err_d;
  logic [5:0][3:0] dig_q, dig_d;

  // ---------------------------------------------------------------------------
  // Preset validation and BCD -> seconds conversion
  // ---------------------------------------------------------------------------
  logic [16:0] hrs_v, min_v, sec_v, load_val;
  logic        ld_ok;

  always_comb begin
    hrs_v    = 17'(ph1) * 17'd10 + 17'(ph2);
    min_v    = 17'(pm1) * 17'd10 + 17'(pm2);
    sec_v    = 17'(ps1) * 17'd10 + 17'(ps2);
    // Out-of-range digits may overflow load_val; they are rejected anyway.
    load_val = hrs_v * 17'd3600 + min_v * 17'd60 + sec_v;
    ld_ok    = (ph1 <= 4'd9) && (ph2 <= 4'd9) && (pm1 <= 4'd9) &&
               (pm2 <= 4'd9) && (ps1 <= 4'd9) && (ps2 <= 4'd9) &&
               (ph1 <= 4'd2) && (hrs_v <= 17'd23) &&
               (pm1 <= 4'd5) && (ps1 <= 4'd5) &&
               (load_val <= 17'(MAX_SEC));
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  logic do_tick;

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    rem_d     = rem_q;
    expired_d = expired_q;
    done_p_d  = 1'b0;
    ld_err_d  = 1'b0;
    do_tick   = 1'b0;

    if (cd) begin
      if (ld) begin
        // A load, valid or not, consumes the edge: no start/pause/decrement.
        if (ld_ok) begin
          preset_d  = load_val;
          rem_d     = load_val;
          state_d   = IDLE;
          expired_d = 1'b0;
        end else begin
          ld_err_d  = 1'b1;
        end
      end else if (start) begin
        unique case (state_q)
          IDLE, PAUSE: if (rem_q != 17'd0) state_d = RUN;
          DONE: if (preset_q != 17'd0) begin
            rem_d     = preset_q;
            expired_d = 1'b0;
            state_d   = RUN;
          end
          RUN:  do_tick = 1'b1;  // start while running: keep counting
          default: ;
        endcase
      end else if (pause && state_q == RUN) begin
        state_d = PAUSE;
      end else if (state_q == RUN) begin
        do_tick = 1'b1;
      end
    end

    if (do_tick) begin
      if (rem_q == 17'd1) begin
        done_p_d  = 1'b1;
        expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (preset_q != 17'd0) begin
          rem_d = preset_q;
        end else begin
          rem_d   = 17'd0;
          state_d = DONE;
        end
`else
        rem_d   = 17'd0;
        state_d = DONE;
`endif
      end else if (rem_q == 17'd0) begin
        // Unreachable in normal use; park in DONE rather than wrap.
        state_d = DONE;
      end else begin
        rem_d = rem_q - 17'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit split of the current count; registered so digits lag REM_CNT by one.
  // ---------------------------------------------------------------------------
  logic [16:0] h_v, hr_v, m_v, s_v;

  always_comb begin
    h_v      = rem_q / 17'd3600;
    hr_v     = rem_q % 17'd3600;
    m_v      = hr_v / 17'd60;
    s_v      = hr_v % 17'd60;
    dig_d[5] = 4'(h_v / 17'd10);
    dig_d[4] = 4'(h_v % 17'd10);
    dig_d[3] = 4'(m_v / 17'd10);
    dig_d[2] = 4'(m_v % 17'd10);
    dig_d[1] = 4'(s_v / 17'd10);
    dig_d[0] = 4'(s_v % 17'd10);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_out or posedge swrst) begin
    if (swrst) begin
      state_q   <= IDLE;
      preset_q  <= 17'd0;
      rem_q     <= 17'd0;
      expired_q <= 1'b0;
      done_p_q  <= 1'b0;
      ld_err_q  <= 1'b0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
      done_p_q  <= done_p_d;
      ld_err_q  <= ld_err_d;
      // Display digits freeze with the rest of the block when cd is low.
      if (cd) dig_q <= dig_d;
    end
  end

  assign REM_CNT = rem_q;
  assign running = (state_q == RUN);
  assign expired = expired_q;
  assign done_p  = done_p_q;
  assign ld_err  = ld_err_q;
  assign ch1     = dig_q[5];
  assign ch2     = dig_q[4];
  assign cm1     = dig_q[3];
  assign cm2     = dig_q[2];
  assign cs1     = dig_q[1];
  assign cs2     = dig_q[0];

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic        clk_out = 1'b0;
  logic        swrst, cd, ld, start, pause;
  logic [3:0]  ph1, ph2, pm1, pm2, ps1, ps2;
  logic [16:0] rem;
  logic [3:0]  ch1, ch2, cm1, cm2, cs1, cs2;
  logic        running, expired, done_p, ld_err;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer dut (
    .clk_out (clk_out), .swrst (swrst), .cd (cd),
    .ld (ld), .start (start), .pause (pause),
    .ph1 (ph1), .ph2 (ph2), .pm1 (pm1), .pm2 (pm2), .ps1 (ps1), .ps2 (ps2),
    .REM_CNT (rem),
    .ch1 (ch1), .ch2 (ch2), .cm1 (cm1), .cm2 (cm2), .cs1 (cs1), .cs2 (cs2),
    .running (running), .expired (expired), .done_p (done_p), .ld_err (ld_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dig(input string tag, input logic [23:0] exp);
    chk(tag, {8'd0, ch1, ch2, cm1, cm2, cs1, cs2}, {8'd0, exp});
  endtask

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic set_p(input logic [3:0] a, b, c, d, e, f);
    ph1 = a; ph2 = b; pm1 = c; pm2 = d; ps1 = e; ps2 = f;
  endtask

  // One-edge load of a preset
  task automatic load(input logic [3:0] a, b, c, d, e, f);
    set_p(a, b, c, d, e, f);
    ld = 1'b1; step(); ld = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    swrst = 1'b1; cd = 1'b1; ld = 1'b0; start = 1'b0; pause = 1'b0;
    set_p(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_rem", rem, 0);
    chk("rst_running", running, 0);
    chk("rst_expired", expired, 0);
    chk("rst_done_p", done_p, 0);
    chk("rst_ld_err", ld_err, 0);
    chk_dig("rst_digits", 24'h000000);
    #4 swrst = 1'b0;

    // ---- 00:01:05 full countdown ----
    load(0, 0, 0, 1, 0, 5);
    chk("t1_load_rem", rem, 65);
    chk("t1_load_running", running, 0);
    chk("t1_load_ld_err", ld_err, 0);
    go();
    chk("t1_start_rem", rem, 65);
    chk("t1_start_running", running, 1);
    for (int i = 1; i <= 64; i++) begin
      step();
      chk("t1_rem", rem, 65 - i);
      chk("t1_done_p_low", done_p, 0);
      if (i == 2) chk_dig("t1_digits_64", 24'h000104);
    end
    step();
    chk("t1_exp_rem", rem, 0);
    chk("t1_exp_done_p", done_p, 1);
    chk("t1_exp_expired", expired, 1);
    chk("t1_exp_running", running, 0);
    step();
    chk("t1_done_p_once", done_p, 0);
    chk("t1_expired_hold", expired, 1);
    chk("t1_rem_floor", rem, 0);
    chk_dig("t1_digits_zero", 24'h000000);
    go();
    chk("t1_restart_rem", rem, 65);
    chk("t1_restart_expired", expired, 0);
    chk("t1_restart_running", running, 1);

    // ---- invalid loads ----
    load(0, 0, 0, 0, 1, 0);
    chk("t2_valid_rem", rem, 10);
    chk("t2_valid_running", running, 0);
    load(0, 0, 6, 0, 0, 0);
    chk("t2_6000_ld_err", ld_err, 1);
    chk("t2_6000_rem", rem, 10);
    step();
    chk("t2_ld_err_pulse", ld_err, 0);
    load(2, 4, 0, 0, 0, 0);
    chk("t2_2400_ld_err", ld_err, 1);
    chk("t2_2400_rem", rem, 10);
    load(0, 0, 0, 0, 0, 10);
    chk("t2_digit10_ld_err", ld_err, 1);

    // ---- pause / resume ----
    go();
    chk("t3_running", running, 1);
    step(); step(); step();
    chk("t3_rem7", rem, 7);
    pause = 1'b1; step(); pause = 1'b0;
    chk("t3_pause_rem", rem, 7);
    chk("t3_pause_running", running, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_rem", rem, 7);
    end
    go();
    chk("t3_resume_rem", rem, 7);
    chk("t3_resume_running", running, 1);
    for (int i = 0; i < 6; i++) step();
    chk("t3_rem1", rem, 1);
    chk("t3_no_done_yet", done_p, 0);
    step();
    chk("t3_exp_rem", rem, 0);
    chk("t3_exp_done_p", done_p, 1);
    go();
    chk("t3_preset_kept", rem, 10);

    // ---- 23:59:59 ----
    load(2, 3, 5, 9, 5, 9);
    chk("t4_load_rem", rem, 86399);
    chk("t4_ld_over_run", running, 0);
    set_p(0, 0, 0, 0, 0, 1);
    ld = 1'b1; start = 1'b1; step(); ld = 1'b0; start = 1'b0;
    chk("t4_ld_start_rem", rem, 1);
    chk("t4_ld_start_idle", running, 0);
    load(2, 3, 5, 9, 5, 9);
    go();
    step();
    chk("t4_rem_86398", rem, 86398);
    step();
    chk_dig("t4_digits", 24'h235958);

    // ---- async reset mid-run ----
    #3 swrst = 1'b1;
    #1;
    chk("t5_rem", rem, 0);
    chk("t5_running", running, 0);
    chk("t5_expired", expired, 0);
    chk_dig("t5_digits", 24'h000000);
    #1 swrst = 1'b0;
    go();
    chk("t5_start_ignored", running, 0);
    chk("t5_start_rem", rem, 0);

    // ---- cd freeze ----
    load(0, 0, 0, 0, 2, 0);
    go();
    step(); step();
    chk("t6_rem18", rem, 18);
    cd = 1'b0; set_p(0, 0, 0, 0, 0, 5); ld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_frozen_rem", rem, 18);
      chk("t6_ld_err_low", ld_err, 0);
    end
    cd = 1'b1; ld = 1'b0;
    step();
    chk("t6_resume_rem", rem, 17);
    chk("t6_running", running, 1);

    // ---- zero preset: start ignored ----
    load(0, 0, 0, 0, 0, 0);
    go();
    chk("t7_zero_running", running, 0);
    chk("t7_zero_done_p", done_p, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    load(0, 0, 0, 0, 0, 3);
    go();
    for (int p = 0; p < 2; p++) begin
      step(); chk("t8_rem2", rem, 2);
      step(); chk("t8_rem1", rem, 1);
      chk("t8_no_pulse", done_p, 0);
      step(); chk("t8_reload", rem, 3);
      chk("t8_done_p", done_p, 1);
      chk("t8_running", running, 1);
      chk("t8_expired", expired, 1);
    end
`else
    load(0, 0, 0, 0, 0, 2);
    go();
    step(); step();
    chk("t8_oneshot_done_p", done_p, 1);
    chk("t8_oneshot_running", running, 0);
    step();
    chk("t8_oneshot_stay", rem, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
